// File: rtl/fetch_gshare_unit_if.sv
// Fetch-stage bus bundle: instruction-memory port, EX resolve/redirect port and IF/ID outputs.
// The bench side uses the master modport and the fetch unit uses the slave modport.
interface fetch_gshare_unit_if #(
    parameter int GHR_BITS = 4
);
    logic                stall_in;
    logic [31:0]         imem_addr_out;
    logic [31:0]         imem_data_in;
    logic                resolve_valid_in;
    logic [31:0]         resolve_pc_in;
    logic [GHR_BITS-1:0] resolve_ghr_in;
    logic                resolve_taken_in;
    logic [31:0]         resolve_target_in;
    logic                resolve_mispredict_in;
    logic [31:0]         resolve_correct_pc_in;
    logic [31:0]         pc_IF_out;
    logic [31:0]         instruction_IF_out;
    logic [31:0]         predicted_pc_IF_out;
    logic                prediction_valid_IF_out;
    logic [GHR_BITS-1:0] ghr_IF_out;

    modport master (
        output stall_in, imem_data_in, resolve_valid_in, resolve_pc_in, resolve_ghr_in,
               resolve_taken_in, resolve_target_in, resolve_mispredict_in, resolve_correct_pc_in,
        input  imem_addr_out, pc_IF_out, instruction_IF_out, predicted_pc_IF_out,
               prediction_valid_IF_out, ghr_IF_out
    );

    modport slave (
        input  stall_in, imem_data_in, resolve_valid_in, resolve_pc_in, resolve_ghr_in,
               resolve_taken_in, resolve_target_in, resolve_mispredict_in, resolve_correct_pc_in,
        output imem_addr_out, pc_IF_out, instruction_IF_out, predicted_pc_IF_out,
               prediction_valid_IF_out, ghr_IF_out
    );
endinterface

// File: rtl/fetch_gshare_unit.sv
// Instruction fetch with gshare direction prediction and a direct-mapped BTB.
// Optional macro FETCH_PERF_CNT_EN adds branch/mispredict performance counters.
module fetch_gshare_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BTB_ENTRIES = 16,
    parameter int          GHR_BITS    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    fetch_gshare_unit_if.slave   bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]          perf_branches_out,
    output logic [31:0]          perf_mispredicts_out
`endif
);
    localparam int IDX   = $clog2(BTB_ENTRIES);
    localparam int TAG_W = 32 - IDX - 2;
    localparam logic [31:0] NOP = 32'h0000_0013;

    function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic up);
        logic [1:0] res;
        if (up) begin
            res = (cnt == 2'b11) ? 2'b11 : cnt + 2'b01;
        end else begin
            res = (cnt == 2'b00) ? 2'b00 : cnt - 2'b01;
        end
        return res;
    endfunction

    logic [31:0]          pc_q, pc_d;
    logic [GHR_BITS-1:0]  ghr_q, ghr_d;
    logic [BTB_ENTRIES-1:0] btb_valid_q;
    logic [TAG_W-1:0]     btb_tag_q    [BTB_ENTRIES];
    logic [31:0]          btb_target_q [BTB_ENTRIES];
    logic [1:0]           pht_q        [BTB_ENTRIES];

    logic [IDX-1:0] idx_s, pht_idx_s, r_idx_s, r_pht_idx_s;
    logic           hit_s, pred_taken_s, kill_s;
    logic [31:0]    predicted_pc_s;
    logic           unused_s;

    assign unused_s = ^bus.resolve_pc_in[1:0];

    // Lookup: arrays read combinationally from the current PC and GHR.
    always_comb begin
        idx_s          = pc_q[IDX+1:2];
        pht_idx_s      = idx_s ^ IDX'(ghr_q);
        hit_s          = btb_valid_q[idx_s] && (btb_tag_q[idx_s] == pc_q[31:IDX+2]);
        pred_taken_s   = hit_s && pht_q[pht_idx_s][1];
        predicted_pc_s = pred_taken_s ? btb_target_q[idx_s] : pc_q + 32'd4;
        kill_s         = bus.resolve_valid_in && bus.resolve_mispredict_in;
        r_idx_s        = bus.resolve_pc_in[IDX+1:2];
        r_pht_idx_s    = r_idx_s ^ IDX'(bus.resolve_ghr_in);
    end

    // IF/ID outputs; a redirect turns the wrong-path slot into a bubble.
    always_comb begin
        bus.imem_addr_out           = pc_q;
        bus.pc_IF_out               = pc_q;
        bus.predicted_pc_IF_out     = predicted_pc_s;
        bus.ghr_IF_out              = ghr_q;
        bus.instruction_IF_out      = kill_s ? NOP : bus.imem_data_in;
        bus.prediction_valid_IF_out = pred_taken_s && !kill_s;
    end

    // Next PC / GHR: redirect beats stall beats advance.
    always_comb begin
        pc_d  = pc_q;
        ghr_d = ghr_q;
        if (kill_s) begin
            pc_d  = bus.resolve_correct_pc_in;
            ghr_d = {bus.resolve_ghr_in[GHR_BITS-2:0], bus.resolve_taken_in};
        end else if (bus.stall_in) begin
            pc_d  = pc_q;
            ghr_d = ghr_q;
        end else begin
            pc_d  = predicted_pc_s;
            ghr_d = hit_s ? {ghr_q[GHR_BITS-2:0], pred_taken_s} : ghr_q;
        end
    end

    // PC and GHR registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q  <= RESET_PC;
            ghr_q <= '0;
        end else begin
            pc_q  <= pc_d;
            ghr_q <= ghr_d;
        end
    end

    // PHT counters and BTB valid bits; resolves train even while stalled.
    always_ff @(posedge clk) begin
        if (!rst) begin
            btb_valid_q <= '0;
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                pht_q[i] <= 2'b01;
            end
        end else if (bus.resolve_valid_in) begin
            pht_q[r_pht_idx_s] <= sat_update(pht_q[r_pht_idx_s], bus.resolve_taken_in);
            if (bus.resolve_taken_in) begin
                btb_valid_q[r_idx_s] <= 1'b1;
            end
        end
    end

    // BTB payload needs no reset: it is qualified by the valid bit.
    always_ff @(posedge clk) begin
        if (rst && bus.resolve_valid_in && bus.resolve_taken_in) begin
            btb_tag_q[r_idx_s]    <= bus.resolve_pc_in[31:IDX+2];
            btb_target_q[r_idx_s] <= bus.resolve_target_in;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_br_q, perf_mp_q;

    // Free-running wrap-around event counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_br_q <= 32'd0;
            perf_mp_q <= 32'd0;
        end else begin
            if (bus.resolve_valid_in) begin
                perf_br_q <= perf_br_q + 32'd1;
            end
            if (kill_s) begin
                perf_mp_q <= perf_mp_q + 32'd1;
            end
        end
    end

    assign perf_branches_out    = perf_br_q;
    assign perf_mispredicts_out = perf_mp_q;
`endif
endmodule

// File: tb/tb_fetch_gshare_unit.sv
// Directed table-driven bench for fetch_gshare_unit; memory returns ~address.
module tb_fetch_gshare_unit;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    fetch_gshare_unit_if #(.GHR_BITS(4)) bus ();

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_br;
    logic [31:0] perf_mp;
`endif

    fetch_gshare_unit #(
        .RESET_PC   (32'h0000_0000),
        .BTB_ENTRIES(16),
        .GHR_BITS   (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_branches_out   (perf_br),
        .perf_mispredicts_out(perf_mp)
`endif
    );

    assign bus.imem_data_in = ~bus.imem_addr_out;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        rv;
        logic [31:0] rpc;
        logic [3:0]  rghr;
        logic        rtk;
        logic [31:0] rtgt;
        logic        rmp;
        logic [31:0] rcpc;
        logic [31:0] e_pc;
        logic [31:0] e_ppc;
        logic        e_pv;
        logic [3:0]  e_ghr;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic stall, input logic rv, input logic [31:0] rpc,
                                input logic [3:0] rghr, input logic rtk, input logic [31:0] rtgt,
                                input logic rmp, input logic [31:0] rcpc, input logic [31:0] e_pc,
                                input logic [31:0] e_ppc, input logic e_pv, input logic [3:0] e_ghr);
        vec_t v;
        v.stall = stall; v.rv = rv; v.rpc = rpc; v.rghr = rghr; v.rtk = rtk; v.rtgt = rtgt;
        v.rmp = rmp; v.rcpc = rcpc; v.e_pc = e_pc; v.e_ppc = e_ppc; v.e_pv = e_pv; v.e_ghr = e_ghr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic stall, input logic rv, input logic [31:0] rpc,
                         input logic [3:0] rghr, input logic rtk, input logic [31:0] rtgt,
                         input logic rmp, input logic [31:0] rcpc);
        bus.stall_in              = stall;
        bus.resolve_valid_in      = rv;
        bus.resolve_pc_in         = rpc;
        bus.resolve_ghr_in        = rghr;
        bus.resolve_taken_in      = rtk;
        bus.resolve_target_in     = rtgt;
        bus.resolve_mispredict_in = rmp;
        bus.resolve_correct_pc_in = rcpc;
    endtask

    task automatic chk_fetch(input string tag, input logic [31:0] e_pc, input logic [31:0] e_ppc,
                             input logic e_pv, input logic [3:0] e_ghr, input logic [31:0] e_ins);
        chk({tag, " pc"},    bus.pc_IF_out, e_pc);
        chk({tag, " addr"},  bus.imem_addr_out, e_pc);
        chk({tag, " ppc"},   bus.predicted_pc_IF_out, e_ppc);
        chk({tag, " pv"},    {31'd0, bus.prediction_valid_IF_out}, {31'd0, e_pv});
        chk({tag, " ghr"},   {28'd0, bus.ghr_IF_out}, {28'd0, e_ghr});
        chk({tag, " instr"}, bus.instruction_IF_out, e_ins);
    endtask

    initial begin
        logic [31:0] e_ins;
        checks   = 0;
        failures = 0;

        //             stall rv rpc          rghr   rtk rtgt          rmp rcpc          e_pc          e_ppc         pv    ghr
        vecs[0]  = mk(1'b0,1'b0,32'h0,       4'h0,1'b0,32'h0,       1'b0,32'h0,       32'h0,        32'h4,        1'b0,4'h0);
        vecs[1]  = mk(1'b0,1'b0,32'h0,       4'h0,1'b0,32'h0,       1'b0,32'h0,       32'h4,        32'h8,        1'b0,4'h0);
        vecs[2]  = mk(1'b0,1'b0,32'h0,       4'h0,1'b0,32'h0,       1'b0,32'h0,       32'h8,        32'hC,        1'b0,4'h0);
        vecs[3]  = mk(1'b0,1'b1,32'h10,      4'h0,1'b1,32'h40,      1'b0,32'h0,       32'hC,        32'h10,       1'b0,4'h0);
        vecs[4]  = mk(1'b0,1'b1,32'h10,      4'h0,1'b1,32'h40,      1'b0,32'h0,       32'h10,       32'h40,       1'b1,4'h0);
        vecs[5]  = mk(1'b1,1'b0,32'h0,       4'h0,1'b0,32'h0,       1'b0,32'h0,       32'h40,       32'h44,       1'b0,4'h1);
        vecs[6]  = mk(1'b1,1'b1,32'h20,      4'h0,1'b1,32'h80,      1'b0,32'h0,       32'h40,       32'h44,       1'b0,4'h1);
        vecs[7]  = mk(1'b1,1'b0,32'h0,       4'h0,1'b0,32'h0,       1'b0,32'h0,       32'h40,       32'h44,       1'b0,4'h1);
        vecs[8]  = mk(1'b1,1'b1,32'h30,      4'h6,1'b0,32'h0,       1'b1,32'h100,     32'h40,       32'h44,       1'b0,4'h1);
        vecs[9]  = mk(1'b0,1'b0,32'h0,       4'h0,1'b0,32'h0,       1'b0,32'h0,       32'h100,      32'h104,      1'b0,4'hC);
        vecs[10] = mk(1'b0,1'b1,32'h54,      4'h0,1'b0,32'h0,       1'b1,32'h20,      32'h104,      32'h108,      1'b0,4'hC);
        vecs[11] = mk(1'b0,1'b1,32'h20,      4'h0,1'b1,32'h90,      1'b0,32'h0,       32'h20,       32'h80,       1'b1,4'h0);
        vecs[12] = mk(1'b0,1'b1,32'h58,      4'h0,1'b0,32'h0,       1'b1,32'h20,      32'h80,       32'h84,       1'b0,4'h1);
        vecs[13] = mk(1'b0,1'b1,32'h7C,      4'h0,1'b1,32'h94,      1'b1,32'h94,      32'h20,       32'h90,       1'b0,4'h0);
        vecs[14] = mk(1'b0,1'b1,32'h18,      4'h0,1'b1,32'h200,     1'b0,32'h0,       32'h94,       32'h98,       1'b0,4'h1);
        vecs[15] = mk(1'b0,1'b1,32'h44,      4'h0,1'b1,32'h18,      1'b1,32'h18,      32'h98,       32'h9C,       1'b0,4'h1);
        vecs[16] = mk(1'b0,1'b0,32'h0,       4'h0,1'b0,32'h0,       1'b0,32'h0,       32'h18,       32'h1C,       1'b0,4'h1);
        vecs[17] = mk(1'b0,1'b0,32'h0,       4'h0,1'b0,32'h0,       1'b0,32'h0,       32'h1C,       32'h20,       1'b0,4'h2);
        vecs[18] = mk(1'b0,1'b0,32'h0,       4'h0,1'b0,32'h0,       1'b0,32'h0,       32'h20,       32'h24,       1'b0,4'h2);
        vecs[19] = mk(1'b0,1'b1,32'h0,       4'h0,1'b0,32'h0,       1'b1,32'hFFFF_FFFC,32'h24,      32'h28,       1'b0,4'h4);
        vecs[20] = mk(1'b0,1'b0,32'h0,       4'h0,1'b0,32'h0,       1'b0,32'h0,       32'hFFFF_FFFC,32'h0,        1'b0,4'h0);
        vecs[21] = mk(1'b0,1'b0,32'h0,       4'h0,1'b0,32'h0,       1'b0,32'h0,       32'h0,        32'h4,        1'b0,4'h0);

        rst = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].stall, vecs[i].rv, vecs[i].rpc, vecs[i].rghr, vecs[i].rtk,
                  vecs[i].rtgt, vecs[i].rmp, vecs[i].rcpc);
            #1;
            e_ins = (vecs[i].rv && vecs[i].rmp) ? 32'h0000_0013 : ~vecs[i].e_pc;
            chk_fetch($sformatf("row%0d", i), vecs[i].e_pc, vecs[i].e_ppc, vecs[i].e_pv,
                      vecs[i].e_ghr, e_ins);
            @(negedge clk);
        end

        // Mid-run reset with a pending taken mispredict: the resolve must be discarded.
        rst = 1'b0;
        drive(1'b0, 1'b1, 32'h24, 4'h0, 1'b1, 32'h300, 1'b1, 32'h500);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        chk_fetch("midrst", 32'h0, 32'h4, 1'b0, 4'h0, 32'hFFFF_FFFF);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_br_rst", perf_br, 32'd0);
        chk("perf_mp_rst", perf_mp, 32'd0);
`endif
        repeat (8) @(negedge clk);
        #1;
        chk_fetch("btb_cleared", 32'h20, 32'h24, 1'b0, 4'h0, ~32'h20);
        @(negedge clk);
        #1;
        chk_fetch("discarded", 32'h24, 32'h28, 1'b0, 4'h0, ~32'h24);
        // One taken resolve must flip a weakly-not-taken counter to predict taken.
        drive(1'b0, 1'b1, 32'h2C, 4'h0, 1'b1, 32'h400, 1'b0, 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        chk_fetch("pre_hit", 32'h28, 32'h2C, 1'b0, 4'h0, ~32'h28);
        @(negedge clk);
        #1;
        chk_fetch("pht_init", 32'h2C, 32'h400, 1'b1, 4'h0, ~32'h2C);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_br_one", perf_br, 32'd1);
        chk("perf_mp_zero", perf_mp, 32'd0);
`endif
        @(negedge clk);
        #1;
        chk_fetch("taken_jump", 32'h400, 32'h404, 1'b0, 4'h1, ~32'h400);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
